// File: rtl/apb_pkg.sv
// Shared APB types: requester FSM state encoding and the ECC register map
// offsets that software targets through this master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [31:0] CTRL           = 32'h0000_0000;
  localparam logic [31:0] DATA_IN        = 32'h0000_0004;
  localparam logic [31:0] CODEWORD_WIDTH = 32'h0000_0008;
  localparam logic [31:0] NOISE          = 32'h0000_000C;

endpackage

// File: rtl/apb_master.sv
// APB requester: turns one host command into one APB transfer and returns a
// held response; misaligned commands and completer timeouts report an error.
module apb_master
  import apb_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_error,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       PREADY
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  apb_state_e                 state_reg, state_next;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic                       pwrite_reg, pwrite_next;
  logic [AMBA_WORD-1:0]       wdata_reg, wdata_next;
  logic [AMBA_WORD-1:0]       rdata_reg, rdata_next;
  logic                       error_reg, error_next;
  logic [CNT_W-1:0]           wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]           wait_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      paddr_reg    <= '0;
      pwrite_reg   <= 1'b0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      error_reg    <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      paddr_reg    <= paddr_next;
      pwrite_reg   <= pwrite_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      error_reg    <= error_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    paddr_next    = paddr_reg;
    pwrite_next   = pwrite_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    error_next    = error_reg;
    wait_cnt_next = wait_cnt_reg;
    wait_inc      = (wait_cnt_reg == CNT_MAX) ? wait_cnt_reg : wait_cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          // Misaligned commands never touch the bus, so PADDR/PWRITE keep the last transfer.
          if (cmd_addr[1:0] != 2'b00) begin
            state_next = RESP;
            error_next = 1'b1;
            rdata_next = '0;
          end else begin
            state_next    = SETUP;
            paddr_next    = cmd_addr;
            pwrite_next   = cmd_write;
            wdata_next    = cmd_write ? cmd_wdata : '0;
            wait_cnt_next = '0;
          end
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_next = RESP;
          error_next = 1'b0;
          rdata_next = pwrite_reg ? '0 : PRDATA;
        end else begin
          wait_cnt_next = wait_inc;
          if ((TIMEOUT_CYCLES != 0) && (wait_inc == TIMEOUT_VAL)) begin
            state_next = RESP;
            error_next = 1'b1;
            rdata_next = '0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign PSEL      = (state_reg == SETUP) || (state_reg == ACCESS);
  assign PENABLE   = (state_reg == ACCESS);
  assign PADDR     = paddr_reg;
  assign PWRITE    = pwrite_reg;
  assign PWDATA    = PSEL ? wdata_reg : '0;
  assign rsp_valid = (state_reg == RESP);
  assign cmd_ready = (state_reg == IDLE) && !rsp_valid;
  assign rsp_rdata = rdata_reg;
  assign rsp_error = error_reg;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, waited read, backpressure, misaligned
// command, timeout and reset during ACCESS, checked with immediate assertions.
module tb_apb_master;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [19:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [19:0] PADDR;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0] PWDATA, PRDATA;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  apb_master #(
    .AMBA_WORD      (32),
    .AMBA_ADDR_WIDTH(20),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a command and returns one cycle after acceptance (SETUP cycle, before its sample point).
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a[19:0];
    cmd_wdata = d;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic stable;
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b1; PRDATA = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", {31'd0, PSEL}, 32'd0);
    chk("rst_penable", {31'd0, PENABLE}, 32'd0);
    chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    chk("rst_paddr", {12'd0, PADDR}, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Zero-wait write to CTRL; rsp_ready already high while no response is pending
    @(posedge clk); #1 rsp_ready = 1'b1;
    send(1'b1, CTRL, 32'h2);
    @(negedge clk);
    chk("wr_setup_psel", {31'd0, PSEL}, 32'd1);
    chk("wr_setup_penable", {31'd0, PENABLE}, 32'd0);
    chk("wr_setup_paddr", {12'd0, PADDR}, 32'h0);
    chk("wr_setup_pwrite", {31'd0, PWRITE}, 32'd1);
    chk("wr_setup_pwdata", PWDATA, 32'h2);
    chk("wr_setup_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("wr_access_psel", {31'd0, PSEL}, 32'd1);
    chk("wr_access_penable", {31'd0, PENABLE}, 32'd1);
    chk("wr_access_pwdata", PWDATA, 32'h2);
    chk("wr_access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("wr_resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_resp_psel", {31'd0, PSEL}, 32'd0);
    chk("wr_resp_penable", {31'd0, PENABLE}, 32'd0);
    chk("wr_resp_error", {31'd0, rsp_error}, 32'd0);
    chk("wr_resp_rdata", rsp_rdata, 32'd0);
    chk("wr_resp_pwdata", PWDATA, 32'd0);
    @(negedge clk);
    chk("wr_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("wr_idle_pwrite_hold", {31'd0, PWRITE}, 32'd1);
    chk("wr_idle_pwdata", PWDATA, 32'd0);
    chk("wr_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Read from DATA_IN with two wait states, then five cycles of response backpressure
    @(posedge clk); #1;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = 32'h1234_5678;
    send(1'b0, DATA_IN, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("rd_setup_paddr", {12'd0, PADDR}, 32'h4);
    chk("rd_setup_pwrite", {31'd0, PWRITE}, 32'd0);
    chk("rd_setup_pwdata", PWDATA, 32'd0);
    @(negedge clk);
    chk("rd_access1_penable", {31'd0, PENABLE}, 32'd1);
    @(negedge clk);
    chk("rd_access2_penable", {31'd0, PENABLE}, 32'd1);
    chk("rd_access2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_access3_penable", {31'd0, PENABLE}, 32'd1);
    chk("rd_access3_paddr", {12'd0, PADDR}, 32'h4);
    @(posedge clk); #1;
    PREADY = 1'b0; PRDATA = 32'h0BAD_F00D;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h6; cmd_wdata = 32'h0;
    @(negedge clk);
    chk("rd_resp_psel", {31'd0, PSEL}, 32'd0);
    chk("rd_resp_error", {31'd0, rsp_error}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    chk("bp_last_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;

    // Misaligned command held through backpressure is taken right after the handshake
    @(negedge clk);
    chk("mis_accept_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mis_accept_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mis_accept_psel", {31'd0, PSEL}, 32'd0);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("mis_rsp_error", {31'd0, rsp_error}, 32'd1);
    chk("mis_rsp_rdata", rsp_rdata, 32'd0);
    chk("mis_psel", {31'd0, PSEL}, 32'd0);
    chk("mis_paddr_hold", {12'd0, PADDR}, 32'h4);
    @(negedge clk);
    chk("mis_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Timeout on a write to NOISE with PREADY held low
    @(posedge clk); #1 PREADY = 1'b0;
    send(1'b1, NOISE, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("to_setup_psel", {31'd0, PSEL}, 32'd1);
    n = 0;
    stable = 1'b1;
    @(negedge clk);
    while (PENABLE === 1'b1 && n < 40) begin
      n++;
      if (PWDATA !== 32'hA5A5_A5A5 || PADDR !== 20'hC) stable = 1'b0;
      @(negedge clk);
    end
    chk("to_access_cycles", n, 32'd16);
    chk("to_bus_stable", {31'd0, stable}, 32'd1);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_error", {31'd0, rsp_error}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    chk("to_psel", {31'd0, PSEL}, 32'd0);
    @(negedge clk);
    chk("to_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset asserted during ACCESS aborts the transfer without a response
    @(posedge clk); #1;
    send(1'b0, CODEWORD_WIDTH, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_access_penable", {31'd0, PENABLE}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_psel", {31'd0, PSEL}, 32'd0);
    chk("rstmid_penable", {31'd0, PENABLE}, 32'd0);
    chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstmid_paddr", {12'd0, PADDR}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; PREADY = 1'b1; PRDATA = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rstrel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstrel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    send(1'b0, CODEWORD_WIDTH, 32'h0);
    @(negedge clk);
    chk("post_rst_setup_paddr", {12'd0, PADDR}, 32'h8);
    @(negedge clk);
    chk("post_rst_access_penable", {31'd0, PENABLE}, 32'd1);
    @(negedge clk);
    chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("post_rst_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    chk("post_rst_rsp_error", {31'd0, rsp_error}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter AMBA_WORD, default 32, APB data width in bits.
REQ-002 Parameter AMBA_ADDR_WIDTH, default 20, APB address width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase wait cycles; 0 disables timeout.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  host command request.
REQ-007 cmd_ready  output  1  block accepts command this cycle.
REQ-008 cmd_write  input  1  1 = APB write, 0 = APB read.
REQ-009 cmd_addr  input  AMBA_ADDR_WIDTH  byte address.
REQ-010 cmd_wdata  input  AMBA_WORD  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  host consumes response.
REQ-013 rsp_rdata  output  AMBA_WORD  read data; 0 for writes and errors.
REQ-014 rsp_error  output  1  misaligned address or timeout.
REQ-015 PADDR  output  AMBA_ADDR_WIDTH; PSEL, PENABLE, PWRITE  output  1 each; PWDATA  output  AMBA_WORD  APB requester signals.
REQ-016 PRDATA  input  AMBA_WORD; PREADY  input  1 (tied high for zero-wait completers).

Function
REQ-017 FSM states IDLE, SETUP, ACCESS, RESP; reset state IDLE.
REQ-018 cmd_ready = 1 only in IDLE with rsp_valid = 0; command accepted on cmd_valid & cmd_ready; cmd fields registered on acceptance.
REQ-019 Accepted command with cmd_addr[1:0] != 0 -> RESP next cycle, rsp_error = 1, rsp_rdata = 0, no APB transfer (PSEL stays 0).
REQ-020 Aligned command -> SETUP next cycle: PSEL = 1, PENABLE = 0, PADDR/PWRITE from registered command, PWDATA = cmd_wdata for writes, 0 for reads.
REQ-021 SETUP -> ACCESS unconditionally after one cycle: PSEL = 1, PENABLE = 1; PADDR, PWRITE, PWDATA stable throughout SETUP and ACCESS.
REQ-022 ACCESS with PREADY = 1 -> RESP; rsp_rdata captures PRDATA for reads, 0 for writes; rsp_error = 0.
REQ-023 ACCESS with PREADY = 0 -> wait counter increments; when counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0) -> RESP with rsp_error = 1, rsp_rdata = 0.
REQ-024 Wait counter width $clog2(TIMEOUT_CYCLES+1), cleared on entry to SETUP, saturating, never wraps.
REQ-025 RESP: rsp_valid = 1, PSEL = PENABLE = 0; rsp_rdata/rsp_error held stable until rsp_ready = 1, then -> IDLE, rsp_valid = 0.
REQ-026 Minimum latency, zero-wait completer: command accepted at edge N, SETUP cycle N+1, ACCESS N+2, rsp_valid asserted from edge N+3.
REQ-027 rsp_ready asserted while rsp_valid = 0 is ignored; cmd_valid outside cmd_ready is ignored with no side effect.
REQ-028 In IDLE and RESP, PADDR and PWRITE hold last transfer values; PWDATA driven 0.
REQ-029 PREADY sampled only in ACCESS; PRDATA sampled only when PREADY = 1 in ACCESS.

Reset
REQ-030 rst low asynchronously: state IDLE, PSEL = PENABLE = PWRITE = 0, PADDR = PWDATA = 0, rsp_valid = rsp_error = 0, rsp_rdata = 0, wait counter 0.
REQ-031 Reset mid-transfer aborts the transfer with no response; first command accepted in the cycle after rst deasserts.

Structure
REQ-032 Shared package apb_pkg holds state enum type and ECC register offsets CTRL = 0x00, DATA_IN = 0x04, CODEWORD_WIDTH = 0x08, NOISE = 0x0C.
REQ-033 Single module, no sub-modules; FSM, command register, wait counter and response register inline.

Verification
REQ-034 Zero-wait write: cmd write addr 0x00 data 0x2 -> SETUP/ACCESS one cycle each, PWDATA 0x2, rsp_valid at accept+3, rsp_error 0.
REQ-035 Read with 2 wait states: addr 0x04, PREADY low 2 cycles, PRDATA 0xDEADBEEF -> ACCESS lasts 3 cycles, rsp_rdata 0xDEADBEEF, rsp_error 0.
REQ-036 Timeout: PREADY held 0, TIMEOUT_CYCLES 16 -> ACCESS ends after 16 cycles, rsp_error 1, rsp_rdata 0, PSEL drops.
REQ-037 Misaligned addr 0x06 -> no PSEL pulse, rsp_error 1 at accept+1.
REQ-038 Backpressure: rsp_ready low 5 cycles -> rsp_valid and data stable, cmd_ready 0 throughout; second command accepted only after handshake.
REQ-039 rst low during ACCESS -> PSEL/PENABLE 0 immediately (asynchronously), no response; next command after release completes normally.
